// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the SRAM port arbiter.
// Optional perf counters are enabled by SRAM_ARB_PERF_EN.
package sram_arb_pkg;

  localparam int MAX_ID_W = 8;

  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
  } resp_t;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int be_w(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter: first requester at or
// after ptr_i, searching upward with wrap.
module rr_arbiter #(
  parameter int N    = 2,
  parameter int ID_W = 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [ID_W-1:0] idx_o
);

  logic [ID_W-1:0] j;
  logic            hit;

  // Scan from farthest to nearest so the nearest hit wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    j     = '0;
    hit   = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      j = ID_W'((int'(ptr_i) + k) % N);
      if (req_i[j]) begin
        idx_o = j;
        hit   = 1'b1;
      end
    end
    if (hit) gnt_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// N-master round-robin bridge onto one fixed-latency SRAM
// port. Optional grant counters under SRAM_ARB_PERF_EN.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int RD_LAT    = 1,
  parameter int CNT_W     = 32
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
  input  logic [N_MASTERS-1:0]          m_req_i,
  input  logic [N_MASTERS*DATA_W/8-1:0] m_wen_i,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_addr_i,
  input  logic [N_MASTERS*DATA_W-1:0]   m_wdata_i,
  output logic [N_MASTERS-1:0]          m_addr_ok_o,
  output logic [N_MASTERS-1:0]          m_data_ok_o,
  output logic [DATA_W-1:0]             m_rdata_o,
  output logic                          s_en_o,
  output logic [DATA_W/8-1:0]           s_wen_o,
  output logic [ADDR_W-1:0]             s_addr_o,
  output logic [DATA_W-1:0]             s_wdata_o,
  input  logic [DATA_W-1:0]             s_rdata_i,
  output logic [N_MASTERS*CNT_W-1:0]    perf_grant_o
);

  localparam int N    = N_MASTERS;
  localparam int BE_W = be_w(DATA_W);
  localparam int ID_W = id_w(N_MASTERS);

  logic [N-1:0]    req;
  logic [N-1:0]    gnt;
  logic [ID_W-1:0] win;
  logic [ID_W-1:0] ptr_q, ptr_d;
  resp_t           resp_d;
  resp_t           pipe_q [RD_LAT];
  resp_t           resp_out;
  logic            out_vld;

  assign req = reset_i ? '0 : m_req_i;

  rr_arbiter #(
    .N    (N),
    .ID_W (ID_W)
  ) u_rr (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (win)
  );

  always_comb begin
    ptr_d = ptr_q;
    if (|gnt) begin
      ptr_d = (int'(win) == N - 1) ? '0
            : ID_W'(int'(win) + 1);
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

  assign m_addr_ok_o = gnt;
  assign s_en_o      = |gnt;
  assign s_wen_o     = (|gnt)
                     ? m_wen_i[int'(win)*BE_W +: BE_W]
                     : '0;
  assign s_addr_o    = m_addr_i[int'(win)*ADDR_W +: ADDR_W];
  assign s_wdata_o   = m_wdata_i[int'(win)*DATA_W +: DATA_W];

  always_comb begin
    resp_d       = '0;
    resp_d.valid = |gnt;
    resp_d.id    = MAX_ID_W'(win);
  end

  // Depth equals slave latency, so it can never back up.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= resp_d;
      for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign resp_out = pipe_q[RD_LAT-1];
  assign out_vld  = resp_out.valid & ~reset_i;

  always_comb begin
    m_data_ok_o = '0;
    for (int i = 0; i < N; i++) begin
      m_data_ok_o[i] = out_vld
                     && (resp_out.id == MAX_ID_W'(i));
    end
  end

  assign m_rdata_o = out_vld ? s_rdata_i : '0;

`ifdef SRAM_ARB_PERF_EN
  logic [CNT_W-1:0] cnt_q [N];
  logic [CNT_W-1:0] cnt_d [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = gnt[i] ? cnt_q[i] + 1'b1 : cnt_q[i];
    end
  end

  always_ff @(posedge clock_i) begin
    for (int i = 0; i < N; i++) begin
      if (reset_i) cnt_q[i] <= '0;
      else         cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    perf_grant_o = '0;
    for (int i = 0; i < N; i++) begin
      perf_grant_o[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end
`else
  assign perf_grant_o = '0;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter at read latencies
// 1, 2 and 3 sharing one master-side stimulus.
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [3:0]  wen0, wen1;
  logic [31:0] addr0, addr1, wd0, wd1;
  logic [7:0]  m_wen;
  logic [63:0] m_addr, m_wdata;

  assign m_wen   = {wen1, wen0};
  assign m_addr  = {addr1, addr0};
  assign m_wdata = {wd1, wd0};

  logic [1:0]  ok1_a, ok1_d, ok2_a, ok2_d, ok3_a, ok3_d;
  logic [31:0] rd1, rd2, rd3;
  logic        sen1, sen2, sen3;
  logic [3:0]  swen1, swen2, swen3;
  logic [31:0] sa1, sa2, sa3, sw1, sw2, sw3;
  logic [31:0] srd1, srd3;
  logic [31:0] srd2;
  logic [7:0]  perf1, perf2, perf3;
  logic [31:0] p3_0, p3_1, p3_2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(
    .N_MASTERS(2), .ADDR_W(32), .DATA_W(32),
    .RD_LAT(1), .CNT_W(4)
  ) dut1 (
    .clock_i(clk), .reset_i(rst), .m_req_i(req),
    .m_wen_i(m_wen), .m_addr_i(m_addr),
    .m_wdata_i(m_wdata), .m_addr_ok_o(ok1_a),
    .m_data_ok_o(ok1_d), .m_rdata_o(rd1),
    .s_en_o(sen1), .s_wen_o(swen1), .s_addr_o(sa1),
    .s_wdata_o(sw1), .s_rdata_i(srd1),
    .perf_grant_o(perf1)
  );

  sram_port_arbiter #(
    .N_MASTERS(2), .ADDR_W(32), .DATA_W(32),
    .RD_LAT(2), .CNT_W(4)
  ) dut2 (
    .clock_i(clk), .reset_i(rst), .m_req_i(req),
    .m_wen_i(m_wen), .m_addr_i(m_addr),
    .m_wdata_i(m_wdata), .m_addr_ok_o(ok2_a),
    .m_data_ok_o(ok2_d), .m_rdata_o(rd2),
    .s_en_o(sen2), .s_wen_o(swen2), .s_addr_o(sa2),
    .s_wdata_o(sw2), .s_rdata_i(srd2),
    .perf_grant_o(perf2)
  );

  sram_port_arbiter #(
    .N_MASTERS(2), .ADDR_W(32), .DATA_W(32),
    .RD_LAT(3), .CNT_W(4)
  ) dut3 (
    .clock_i(clk), .reset_i(rst), .m_req_i(req),
    .m_wen_i(m_wen), .m_addr_i(m_addr),
    .m_wdata_i(m_wdata), .m_addr_ok_o(ok3_a),
    .m_data_ok_o(ok3_d), .m_rdata_o(rd3),
    .s_en_o(sen3), .s_wen_o(swen3), .s_addr_o(sa3),
    .s_wdata_o(sw3), .s_rdata_i(srd3),
    .perf_grant_o(perf3)
  );

  // Latency-1 byte-enabled memory behind dut1.
  bit [31:0] mem [bit [31:0]];
  always @(posedge clk) begin
    bit [31:0] w;
    if (sen1) begin
      w = mem.exists(sa1) ? mem[sa1] : 32'h0;
      for (int b = 0; b < 4; b++)
        if (swen1[b]) w[8*b +: 8] = sw1[8*b +: 8];
      mem[sa1] = w;
      srd1 <= w;
    end
  end

  // Latency-3 slave returning a tag derived from the address.
  always @(posedge clk) begin
    p3_0 <= sa3 ^ 32'hA5A5_0000;
    p3_1 <= p3_0;
    p3_2 <= p3_1;
  end
  assign srd3 = p3_2;
  assign srd2 = 32'h0;

  task automatic next;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    req = 2'b00;
    wen0 = 4'h0; wen1 = 4'h0;
    addr0 = '0; addr1 = '0;
    wd0 = '0; wd1 = '0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    idle_inputs();
    next();
    next();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 1'b1;
    req = 2'b11;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (ok1_a !== 2'b00) begin
        errors++;
        $display("FAIL rst_addr_ok: got %b want 00", ok1_a);
      end
      checks++;
      if (ok1_d !== 2'b00) begin
        errors++;
        $display("FAIL rst_data_ok: got %b want 00", ok1_d);
      end
      checks++;
      if ({sen1, swen1} !== 5'b0) begin
        errors++;
        $display("FAIL rst_s_en: got %b want 0", {sen1, swen1});
      end
      checks++;
      if (rd1 !== 32'h0) begin
        errors++;
        $display("FAIL rst_rdata: got %h want 0", rd1);
      end
      next();
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ok1_a !== 2'b01) begin
      errors++;
      $display("FAIL rst_first_grant: got %b want 01", ok1_a);
    end
    next();
    req = 2'b00;
  endtask

  task automatic test_round_robin;
    logic [1:0] exp_a, prev;
    do_reset();
    req  = 2'b11;
    prev = 2'b00;
    for (int k = 0; k < 6; k++) begin
      exp_a = (k % 2 == 1) ? 2'b10 : 2'b01;
      @(negedge clk);
      checks++;
      if (ok1_a !== exp_a) begin
        errors++;
        $display("FAIL rr_grant%0d: got %b want %b", k, ok1_a, exp_a);
      end
      checks++;
      if (ok3_a !== exp_a) begin
        errors++;
        $display("FAIL rr_grant_l3_%0d: got %b want %b", k, ok3_a, exp_a);
      end
      checks++;
      if (ok1_d !== prev) begin
        errors++;
        $display("FAIL rr_data%0d: got %b want %b", k, ok1_d, prev);
      end
      prev = exp_a;
      next();
    end
    req = 2'b00;
    @(negedge clk);
    checks++;
    if (ok1_d !== 2'b10) begin
      errors++;
      $display("FAIL rr_data_last: got %b want 10", ok1_d);
    end
    next();
  endtask

  task automatic test_write_read;
    req = 2'b10; wen1 = 4'hF;
    addr1 = 32'h100; wd1 = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if (ok1_a !== 2'b10) begin
      errors++;
      $display("FAIL wr_grant: got %b want 10", ok1_a);
    end
    checks++;
    if ({swen1, sa1, sw1} !== {4'hF, 32'h100, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL wr_slave: got %h %h %h want f 100 deadbeef",
               swen1, sa1, sw1);
    end
    next();
    req = 2'b01; wen1 = 4'h0; wen0 = 4'h0;
    addr0 = 32'h100;
    @(negedge clk);
    checks++;
    if ({ok1_a, swen1, sa1} !== {2'b01, 4'h0, 32'h100}) begin
      errors++;
      $display("FAIL rd_issue: got %b %h %h want 01 0 100",
               ok1_a, swen1, sa1);
    end
    checks++;
    if (ok1_d !== 2'b10) begin
      errors++;
      $display("FAIL wr_data_ok: got %b want 10", ok1_d);
    end
    next();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (ok1_d !== 2'b01) begin
      errors++;
      $display("FAIL rd_data_ok: got %b want 01", ok1_d);
    end
    checks++;
    if (rd1 !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL rd_data: got %h want deadbeef", rd1);
    end
    next();
  endtask

  task automatic test_back_to_back;
    logic [1:0]  exp_a, exp_d;
    logic [31:0] exp_r;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      if (k < 4) begin
        req = 2'b01;
        addr0 = 32'h10 + 32'(4 * k);
      end else begin
        req = 2'b00;
      end
      exp_a = (k < 4) ? 2'b01 : 2'b00;
      exp_d = (k >= 3 && k < 7) ? 2'b01 : 2'b00;
      exp_r = (32'h10 + 32'(4 * (k - 3))) ^ 32'hA5A5_0000;
      @(negedge clk);
      checks++;
      if (ok3_a !== exp_a) begin
        errors++;
        $display("FAIL b2b_grant%0d: got %b want %b", k, ok3_a, exp_a);
      end
      checks++;
      if (ok3_d !== exp_d) begin
        errors++;
        $display("FAIL b2b_data%0d: got %b want %b", k, ok3_d, exp_d);
      end
      if (k >= 3 && k < 7) begin
        checks++;
        if (rd3 !== exp_r) begin
          errors++;
          $display("FAIL b2b_rdata%0d: got %h want %h", k, rd3, exp_r);
        end
      end
      next();
    end
  endtask

  task automatic test_reset_drop;
    do_reset();
    req = 2'b01;
    @(negedge clk);
    checks++;
    if (ok2_a !== 2'b01) begin
      errors++;
      $display("FAIL drop_grant: got %b want 01", ok2_a);
    end
    next();
    req = 2'b00;
    rst = 1'b1;
    @(negedge clk);
    next();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (ok2_d !== 2'b00) begin
        errors++;
        $display("FAIL drop_data%0d: got %b want 00", c, ok2_d);
      end
      next();
    end
  endtask

  task automatic test_req_withdraw;
    do_reset();
    req = 2'b11;
    @(negedge clk);
    next();
    req = 2'b00;
    @(negedge clk);
    checks++;
    if ({sen1, ok1_a} !== 3'b000) begin
      errors++;
      $display("FAIL withdraw_idle: got %b want 000", {sen1, ok1_a});
    end
    next();
    req = 2'b11;
    @(negedge clk);
    checks++;
    if (ok1_a !== 2'b10) begin
      errors++;
      $display("FAIL withdraw_ptr: got %b want 10", ok1_a);
    end
    next();
    req = 2'b00;
  endtask

  task automatic test_perf;
    do_reset();
    req = 2'b10;
    for (int k = 0; k < 17; k++) next();
    req = 2'b00;
    @(negedge clk);
`ifdef SRAM_ARB_PERF_EN
    checks++;
    if (perf1 !== 8'h10) begin
      errors++;
      $display("FAIL perf_count: got %h want 10", perf1);
    end
`else
    checks++;
    if (perf1 !== 8'h00) begin
      errors++;
      $display("FAIL perf_tied: got %h want 00", perf1);
    end
`endif
    next();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_write_read();
    test_back_to_back();
    test_reset_drop();
    test_req_withdraw();
    test_perf();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
